// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - qualifies PLL lock and sequences the synchronous design reset
module pll_reset_sequencer #(
    parameter int LOCK_CYCLES = 1024,
    parameter int HOLD_CYCLES = 16,
    parameter int LOSS_FILTER = 2,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   locked,
    input  logic                   lost_clear,
    output logic                   sys_reset,
    output logic                   ready,
    output logic                   lock_lost,
    output logic [COUNT_WIDTH-1:0] relock_count
);

    localparam int MAX_LH = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
    localparam int MAX_C  = (MAX_LH > LOSS_FILTER) ? MAX_LH : LOSS_FILTER;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0]          LOCK_LAST = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0]          HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]          LOSS_LAST = CW'(LOSS_FILTER - 1);
    localparam logic [COUNT_WIDTH-1:0] RELOCK_MAX = {COUNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   sync1_q, sync2_q;
    logic                   sys_reset_q, sys_reset_d;
    logic                   lock_lost_q, lock_lost_d;
    logic [COUNT_WIDTH-1:0] relock_q, relock_d;
    logic                   loss_event;
    logic                   locked_s;

    assign locked_s = sync2_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        loss_event = 1'b0;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (!locked_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HOLD: begin
                // Any low sample here restarts qualification without counting as a loss.
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                if (locked_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LOSS_LAST) begin
                    state_d    = ST_WAIT_LOCK;
                    cnt_d      = '0;
                    loss_event = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase

        // A loss on the same edge as lost_clear keeps the flag set.
        if (loss_event) begin
            lock_lost_d = 1'b1;
        end else if (lost_clear) begin
            lock_lost_d = 1'b0;
        end else begin
            lock_lost_d = lock_lost_q;
        end

        relock_d = relock_q;
        if (loss_event && (relock_q != RELOCK_MAX)) begin
            relock_d = relock_q + COUNT_WIDTH'(1);
        end

        sys_reset_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_WAIT_LOCK;
            cnt_q       <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sys_reset_q <= 1'b1;
            lock_lost_q <= 1'b0;
            relock_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync1_q     <= locked;
            sync2_q     <= sync1_q;
            sys_reset_q <= sys_reset_d;
            lock_lost_q <= lock_lost_d;
            relock_q    <= relock_d;
        end
    end

    assign sys_reset    = sys_reset_q;
    assign ready        = ~sys_reset_q;
    assign lock_lost    = lock_lost_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - randomized self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

    localparam int LOCK = 4;
    localparam int HOLD = 2;
    localparam int LOSS = 2;
    localparam int CW   = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          locked;
    logic          lost_clear;
    logic          sys_reset;
    logic          ready;
    logic          lock_lost;
    logic [CW-1:0] relock_count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: lock qualifies after LOCK+HOLD consecutive synchronised-high
    // samples; in run, LOSS consecutive low samples constitute a loss.
    bit m_s1, m_s2, m_run, m_lost;
    int m_streak, m_lows, m_relock;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .LOCK_CYCLES(LOCK),
        .HOLD_CYCLES(HOLD),
        .LOSS_FILTER(LOSS),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .locked(locked),
        .lost_clear(lost_clear),
        .sys_reset(sys_reset),
        .ready(ready),
        .lock_lost(lock_lost),
        .relock_count(relock_count)
    );

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit ls;
        bit loss;
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_run = 0; m_lost = 0;
            m_streak = 0; m_lows = 0; m_relock = 0;
        end else begin
            ls   = m_s2;
            loss = 0;
            if (!m_run) begin
                if (ls) begin
                    m_streak++;
                    if (m_streak == LOCK + HOLD) begin
                        m_run  = 1;
                        m_lows = 0;
                    end
                end else begin
                    m_streak = 0;
                end
            end else begin
                if (!ls) begin
                    m_lows++;
                    if (m_lows == LOSS) begin
                        loss     = 1;
                        m_run    = 0;
                        m_streak = 0;
                    end
                end else begin
                    m_lows = 0;
                end
            end
            if (loss) begin
                m_lost = 1;
                if (m_relock < (1 << CW) - 1) m_relock++;
            end else if (lost_clear) begin
                m_lost = 0;
            end
            m_s2 = m_s1;
            m_s1 = locked;
        end
    endtask

    // Called at a falling edge: apply inputs, take one rising edge, check at the next falling edge.
    task automatic cycle(input bit l, input bit c, input bit r);
        locked     = l;
        lost_clear = c;
        reset      = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
        expect_eq("sys_reset", 32'(sys_reset), 32'(!m_run));
        expect_eq("ready", 32'(ready), 32'(m_run));
        expect_eq("lock_lost", 32'(lock_lost), 32'(m_lost));
        expect_eq("relock_count", 32'(relock_count), 32'(m_relock));
    endtask

    task automatic expect_reset_state(input string tag);
        expect_eq({tag, "_sys_reset"}, 32'(sys_reset), 32'd1);
        expect_eq({tag, "_ready"}, 32'(ready), 32'd0);
        expect_eq({tag, "_lock_lost"}, 32'(lock_lost), 32'd0);
        expect_eq({tag, "_relock"}, 32'(relock_count), 32'd0);
    endtask

    task automatic full_qualify(input string tag);
        for (int e = 1; e <= LOCK + HOLD + 2; e++) begin
            cycle(1, 0, 0);
            expect_eq({tag, "_sys_reset"}, 32'(sys_reset), (e < LOCK + HOLD + 2) ? 32'd1 : 32'd0);
        end
        expect_eq({tag, "_ready"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int sat_exp [5];
        int hold_len;
        bit lv;
        sat_exp = '{1, 2, 3, 3, 3};
        locked = 0; lost_clear = 0; reset = 1;
        @(negedge clk);

        for (int i = 0; i < 3; i++) cycle(0, 0, 1);
        expect_reset_state("reset");

        full_qualify("nominal");
        expect_eq("nominal_lock_lost", 32'(lock_lost), 32'd0);
        expect_eq("nominal_relock", 32'(relock_count), 32'd0);

        cycle(0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0);
        expect_eq("glitch_ignored", 32'(sys_reset), 32'd0);

        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        expect_eq("loss_edge3", 32'(sys_reset), 32'd0);
        cycle(1, 0, 0);
        expect_eq("loss_edge4", 32'(sys_reset), 32'd1);
        expect_eq("loss_lock_lost", 32'(lock_lost), 32'd1);
        expect_eq("loss_relock", 32'(relock_count), 32'd1);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0);
        expect_eq("relock_run", 32'(ready), 32'd1);

        cycle(1, 1, 0);
        expect_eq("clear_alone", 32'(lock_lost), 32'd0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        expect_eq("clear_race", 32'(lock_lost), 32'd1);
        expect_eq("clear_race_relock", 32'(relock_count), 32'd2);

        for (int i = 0; i < 12; i++) cycle(1, 0, 0);
        cycle(1, 0, 1);
        expect_reset_state("rst_run");
        for (int i = 0; i < LOCK + 3; i++) cycle(1, 0, 0);
        cycle(1, 0, 1);
        expect_reset_state("rst_hold");
        full_qualify("requal");

        cycle(1, 0, 1);
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 12; i++) cycle(1, 0, 0);
            for (int i = 0; i < 4; i++) cycle(0, 0, 0);
            expect_eq($sformatf("sat_%0d", k), 32'(relock_count), 32'(sat_exp[k]));
        end

        for (int n = 0; n < 300; n++) begin
            lv       = ($urandom_range(0, 3) != 0);
            hold_len = lv ? $urandom_range(1, 14) : $urandom_range(1, 4);
            for (int i = 0; i < hold_len; i++) begin
                cycle(lv, ($urandom_range(0, 7) == 0), ($urandom_range(0, 149) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
